// File: rtl/pc_exception_unit.sv
// Next-PC and exception stage: owns PC, EPC, fault destination index, cause,
// handler flag and a saturating count of taken exceptions. Raises Err on
// signed overflow of add/addi/sub, masked while the handler is running.
module pc_exception_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180,
  parameter int          CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Instruction,
  input  logic                 PCWrite,
  input  logic                 PCWriteCond,
  input  logic                 Zero,
  input  logic [1:0]           PCSource,
  input  logic [1:0]           PCErrSource,
  input  logic                 EPCWrite,
  input  logic                 ErrTargetWrite,
  input  logic [31:0]          ALUInA,
  input  logic [31:0]          ALUInB,
  input  logic [31:0]          ALUResult,
  input  logic [31:0]          ALUOutReg,
  input  logic [31:0]          RsData,
  output logic [31:0]          PC,
  output logic                 Err,
  output logic [31:0]          EPC,
  output logic [4:0]           ErrTarget,
  output logic [1:0]           Cause,
  output logic                 InHandler,
  output logic [CNT_WIDTH-1:0] ErrCount
);

  localparam logic [1:0] CAUSE_ADD = 2'b01;
  localparam logic [1:0] CAUSE_SUB = 2'b10;

  typedef struct packed {
    logic       is_add;
    logic       is_sub;
    logic [4:0] dst;
  } dec_t;

  dec_t       dec;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       same_sign;
  logic       res_flip;
  logic       ovf;
  logic [1:0] pend_cause;
  logic       pc_en;
  logic       handler_ret;
  logic [31:0] pc_next;

  // Only the sign bits of the operands matter for overflow detection.
  logic unused_alu;
  assign unused_alu = ^{ALUInA[30:0], ALUInB[30:0]};

  assign opcode = Instruction[31:26];
  assign funct  = Instruction[5:0];

  // Decode the signed arithmetic ops and the destination field (rd for R-type, rt otherwise).
  always_comb begin
    dec        = '0;
    dec.is_add = ((opcode == 6'h00) && (funct == 6'h20)) || (opcode == 6'h08);
    dec.is_sub = (opcode == 6'h00) && (funct == 6'h22);
    dec.dst    = (opcode == 6'h00) ? Instruction[15:11] : Instruction[20:16];
  end

  // Overflow: add needs equal operand signs, sub needs differing ones; either way the result sign flips from A.
  assign same_sign = (ALUInA[31] == ALUInB[31]);
  assign res_flip  = (ALUResult[31] != ALUInA[31]);
  assign ovf       = res_flip & ((dec.is_add & same_sign) | (dec.is_sub & ~same_sign));
  assign Err       = ovf & ~InHandler;

  assign pc_en       = PCWrite | (PCWriteCond & Zero);
  assign handler_ret = PCWrite & (PCErrSource == 2'b10);

  // Next PC selection; the exception source overrides the normal source, 11 holds.
  always_comb begin
    pc_next = PC;
    unique case (PCErrSource)
      2'b01: pc_next = HANDLER_ADDR;
      2'b10: pc_next = EPC;
      2'b00: begin
        unique case (PCSource)
          2'b00: pc_next = ALUResult;
          2'b01: pc_next = ALUOutReg;
          2'b10: pc_next = {PC[31:28], Instruction[25:0], 2'b00};
          2'b11: pc_next = RsData;
          default: pc_next = PC;
        endcase
      end
      default: pc_next = PC;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      PC <= RESET_PC;
    else if (pc_en)  PC <= pc_next;
  end

  // Latch the overflow kind while ALU inputs are valid; the controller's error cycle reads it later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   pend_cause <= 2'b00;
    else if (Err) pend_cause <= dec.is_add ? CAUSE_ADD : CAUSE_SUB;
  end

  // Exception entry/return bookkeeping; entry wins over a simultaneous return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      EPC       <= 32'h0;
      Cause     <= 2'b00;
      InHandler <= 1'b0;
      ErrCount  <= '0;
    end else if (EPCWrite) begin
      EPC       <= PC;
      Cause     <= pend_cause;
      InHandler <= 1'b1;
      if (ErrCount != {CNT_WIDTH{1'b1}}) ErrCount <= ErrCount + CNT_WIDTH'(1);
    end else if (handler_ret) begin
      InHandler <= 1'b0;
    end
  end

  // Destination register of the faulting instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              ErrTarget <= 5'd0;
    else if (ErrTargetWrite) ErrTarget <= dec.dst;
  end

endmodule

// File: tb/tb_pc_exception_unit.sv
// Directed bench for pc_exception_unit with a spec-level reference model
// checked every cycle plus hand-computed literal expectations.
module tb_pc_exception_unit;

  localparam logic [31:0] HANDLER = 32'h0000_0180;
  localparam int          CW      = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instruction;
  logic        PCWrite, PCWriteCond, Zero, EPCWrite, ErrTargetWrite;
  logic [1:0]  PCSource, PCErrSource;
  logic [31:0] ALUInA, ALUInB, ALUResult, ALUOutReg, RsData;
  logic [31:0] PC, EPC;
  logic        Err, InHandler;
  logic [4:0]  ErrTarget;
  logic [1:0]  Cause;
  logic [CW-1:0] ErrCount;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_exception_unit #(.RESET_PC(32'h0), .HANDLER_ADDR(HANDLER), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .Instruction(Instruction),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Zero(Zero),
    .PCSource(PCSource), .PCErrSource(PCErrSource),
    .EPCWrite(EPCWrite), .ErrTargetWrite(ErrTargetWrite),
    .ALUInA(ALUInA), .ALUInB(ALUInB), .ALUResult(ALUResult),
    .ALUOutReg(ALUOutReg), .RsData(RsData),
    .PC(PC), .Err(Err), .EPC(EPC), .ErrTarget(ErrTarget), .Cause(Cause),
    .InHandler(InHandler), .ErrCount(ErrCount)
  );

  // Instruction encodings used by the stimulus.
  localparam logic [31:0] I_ADD  = {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20};
  localparam logic [31:0] I_ADDU = {6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h21};
  localparam logic [31:0] I_SUB  = {6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h22};
  localparam logic [31:0] I_ADDI = {6'h08, 5'd1, 5'd9, 16'h0001};
  localparam logic [31:0] I_BEQ  = {6'h04, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] I_J    = {6'h02, 26'h000_0010};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: true signed arithmetic decides overflow, independent of result bits.
  function automatic logic [1:0] cause_of(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    bit is_add, is_sub;
    is_add = (ins[31:26] == 6'h00 && ins[5:0] == 6'h20) || ins[31:26] == 6'h08;
    is_sub = (ins[31:26] == 6'h00 && ins[5:0] == 6'h22);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_add) begin
      s = sa + sb;
      if (s > 64'sd2147483647 || s < -64'sd2147483648) return 2'b01;
    end
    if (is_sub) begin
      s = sa - sb;
      if (s > 64'sd2147483647 || s < -64'sd2147483648) return 2'b10;
    end
    return 2'b00;
  endfunction

  // Model state.
  logic [31:0] m_pc, m_epc;
  logic [4:0]  m_tgt;
  logic [1:0]  m_cause, m_pend;
  logic        m_inh;
  int          m_taken;
  logic [31:0] o_pc;
  logic [1:0]  o_pend, c_now;

  // Model update from the specification's edge rules.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_tgt = 5'd0; m_cause = 2'b00;
      m_pend = 2'b00; m_inh = 1'b0; m_taken = 0;
    end else begin
      o_pc   = m_pc;
      o_pend = m_pend;
      c_now  = cause_of(Instruction, ALUInA, ALUInB);
      if (c_now != 2'b00 && !m_inh) m_pend = c_now;
      if (PCWrite || (PCWriteCond && Zero)) begin
        if (PCErrSource == 2'b01) m_pc = HANDLER;
        else if (PCErrSource == 2'b10) m_pc = m_epc;
        else if (PCErrSource == 2'b00) begin
          if (PCSource == 2'b00) m_pc = ALUResult;
          else if (PCSource == 2'b01) m_pc = ALUOutReg;
          else if (PCSource == 2'b10) m_pc = {o_pc[31:28], Instruction[25:0], 2'b00};
          else m_pc = RsData;
        end
      end
      if (EPCWrite) begin
        m_epc = o_pc; m_cause = o_pend; m_inh = 1'b1; m_taken++;
      end else if (PCWrite && PCErrSource == 2'b10) begin
        m_inh = 1'b0;
      end
      if (ErrTargetWrite)
        m_tgt = (Instruction[31:26] == 6'h00) ? Instruction[15:11] : Instruction[20:16];
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("PC", PC, m_pc);
      chk("Err", 32'(Err), 32'((cause_of(Instruction, ALUInA, ALUInB) != 2'b00) && !m_inh));
      chk("EPC", EPC, m_epc);
      chk("ErrTarget", 32'(ErrTarget), 32'(m_tgt));
      chk("Cause", 32'(Cause), 32'(m_cause));
      chk("InHandler", 32'(InHandler), 32'(m_inh));
      chk("ErrCount", 32'(ErrCount), (m_taken > 255) ? 32'd255 : 32'(m_taken));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    Instruction = 32'h0; PCWrite = 0; PCWriteCond = 0; Zero = 0;
    PCSource = 2'b00; PCErrSource = 2'b00; EPCWrite = 0; ErrTargetWrite = 0;
    ALUInA = 0; ALUInB = 0; ALUResult = 0; ALUOutReg = 0; RsData = 0;
  endtask

  // Drive an ALU operation with a consistent result.
  task automatic alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    Instruction = ins; ALUInA = a; ALUInB = b;
    ALUResult = (ins[31:26] == 6'h00 && (ins[5:0] == 6'h22 || ins[5:0] == 6'h23)) ? a - b : a + b;
  endtask

  task automatic set_pc(input logic [31:0] v);
    idle(); PCWrite = 1; ALUResult = v; step(); idle();
  endtask

  initial begin
    idle();
    #12;
    chk("rst PC", PC, 32'h0);
    chk("rst Err", 32'(Err), 32'h0);
    chk("rst InHandler", 32'(InHandler), 32'h0);
    chk("rst ErrCount", 32'(ErrCount), 32'h0);
    reset = 1'b1;

    // IF edge
    PCWrite = 1; ALUResult = 32'h4; step(); idle();
    chk("if PC", PC, 32'h4);
    chk("if ErrCount", 32'(ErrCount), 32'h0);

    // add overflow then exception entry
    set_pc(32'h10);
    alu(I_ADD, 32'h7FFF_FFFF, 32'h1); #1;
    chk("add Err", 32'(Err), 32'h1);
    step(); idle();
    Instruction = I_ADD; PCWrite = 1; PCErrSource = 2'b01; EPCWrite = 1; ErrTargetWrite = 1;
    step(); idle();
    chk("entry PC", PC, 32'h180);
    chk("entry EPC", EPC, 32'h10);
    chk("entry Cause", 32'(Cause), 32'h1);
    chk("entry ErrTarget", 32'(ErrTarget), 32'h5);
    chk("entry InHandler", 32'(InHandler), 32'h1);
    chk("entry ErrCount", 32'(ErrCount), 32'h1);

    // nested fault masked, then return
    alu(I_SUB, 32'h8000_0000, 32'h1); #1;
    chk("nested Err", 32'(Err), 32'h0);
    step(); idle();
    PCWrite = 1; PCErrSource = 2'b10; step(); idle();
    chk("ret PC", PC, 32'h10);
    chk("ret InHandler", 32'(InHandler), 32'h0);
    chk("ret Cause kept", 32'(Cause), 32'h1);

    // beq not taken / taken
    Instruction = I_BEQ; PCWriteCond = 1; PCSource = 2'b01; ALUOutReg = 32'h40; Zero = 0;
    step();
    chk("beq nt PC", PC, 32'h10);
    Zero = 1; step(); idle();
    chk("beq t PC", PC, 32'h40);

    // jump keeps upper nibble
    set_pc(32'h3000_0000);
    Instruction = I_J; PCWrite = 1; PCSource = 2'b10; step(); idle();
    chk("j PC", PC, 32'h3000_0040);

    // jr
    PCWrite = 1; PCSource = 2'b11; RsData = 32'h0000_2468; step(); idle();
    chk("jr PC", PC, 32'h0000_2468);

    // reserved exception source holds PC
    PCWrite = 1; PCErrSource = 2'b11; ALUResult = 32'hDEAD_0000; step(); idle();
    chk("rsv PC", PC, 32'h0000_2468);

    // addu never overflows
    alu(I_ADDU, 32'h7FFF_FFFF, 32'h1); #1;
    chk("addu Err", 32'(Err), 32'h0);
    step(); idle();

    // addi overflow, rt destination
    alu(I_ADDI, 32'h7FFF_FFFF, 32'h1); #1;
    chk("addi Err", 32'(Err), 32'h1);
    step(); idle();
    Instruction = I_ADDI; PCWrite = 1; PCErrSource = 2'b01; EPCWrite = 1; ErrTargetWrite = 1;
    step(); idle();
    chk("addi ErrTarget", 32'(ErrTarget), 32'h9);
    chk("addi Cause", 32'(Cause), 32'h1);
    chk("addi EPC", EPC, 32'h0000_2468);
    PCWrite = 1; PCErrSource = 2'b10; step(); idle();

    // sub overflow outside the handler
    alu(I_SUB, 32'h8000_0000, 32'h1); #1;
    chk("sub Err", 32'(Err), 32'h1);
    step(); idle();
    PCWrite = 1; PCErrSource = 2'b01; EPCWrite = 1; step(); idle();
    chk("sub Cause", 32'(Cause), 32'h2);
    chk("sub ErrCount", 32'(ErrCount), 32'h3);

    // entry and return on the same edge: entry wins
    PCWrite = 1; PCErrSource = 2'b10; EPCWrite = 1; step(); idle();
    chk("both InHandler", 32'(InHandler), 32'h1);
    chk("both EPC", EPC, 32'h180);
    chk("both PC", PC, 32'h0000_2468);
    PCWrite = 1; PCErrSource = 2'b10; step(); idle();

    // saturate the counter
    for (int i = 0; i < 300; i++) begin
      PCWrite = 1; PCErrSource = 2'b01; EPCWrite = 1; step(); idle();
      PCWrite = 1; PCErrSource = 2'b10; step(); idle();
    end
    chk("sat ErrCount", 32'(ErrCount), 32'd255);

    // reset between the Err cycle and the EPCWrite edge
    alu(I_ADD, 32'h7FFF_FFFF, 32'h1); step(); idle();
    PCWrite = 1; PCErrSource = 2'b01; EPCWrite = 1; ErrTargetWrite = 1;
    #2 reset = 1'b0;
    #1;
    chk("mid PC", PC, 32'h0);
    chk("mid EPC", EPC, 32'h0);
    chk("mid Cause", 32'(Cause), 32'h0);
    chk("mid InHandler", 32'(InHandler), 32'h0);
    chk("mid ErrCount", 32'(ErrCount), 32'h0);
    chk("mid ErrTarget", 32'(ErrTarget), 32'h0);
    chk("mid Err", 32'(Err), 32'h0);
    step(); idle();
    reset = 1'b1;
    step(); step();
    chk("post EPC", EPC, 32'h0);
    chk("post ErrCount", 32'(ErrCount), 32'h0);
    // pending cause was discarded by reset
    EPCWrite = 1; step(); idle();
    chk("post Cause", 32'(Cause), 32'h0);
    chk("post count", 32'(ErrCount), 32'h1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_exception_unit.md
Name: pc_exception_unit

Overview:
- Next-PC and exception stage directly downstream of the multicycle controller.
- Consumes PCWrite, PCWriteCond, PCSource, PCErrSource, EPCWrite and ErrTargetWrite, and owns the PC register, EPC, fault-destination index, cause register and error counter.
- Produces the Err input the controller samples in its R-type and I-type execute states.
- Detects signed overflow of add/sub/addi from the ALU operands and result.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
HANDLER_ADDR, 32'h0000_0180, PC loaded when PCErrSource=01
CNT_WIDTH, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
Instruction  input  32  IR contents; OpCode=[31:26], Funct=[5:0], jump index=[25:0]
PCWrite  input  1  unconditional PC update
PCWriteCond  input  1  PC update qualified by Zero
Zero  input  1  ALU zero flag, same cycle
PCSource  input  2  00 ALUResult, 01 ALUOutReg, 10 jump target, 11 RsData
PCErrSource  input  2  00 normal (use PCSource), 01 HANDLER_ADDR, 10 EPC, 11 reserved
EPCWrite  input  1  capture EPC/Cause, enter handler
ErrTargetWrite  input  1  capture fault destination register index
ALUInA  input  32  ALU operand A, same cycle
ALUInB  input  32  ALU operand B, same cycle
ALUResult  input  32  combinational ALU result
ALUOutReg  input  32  registered ALU result (branch target)
RsData  input  32  register-file rs read data (jr/jalr)
PC  output  32  current program counter
Err  output  1  combinational overflow exception request
EPC  output  32  exception return address
ErrTarget  output  5  destination register index of faulting instruction
Cause  output  2  00 none, 01 add/addi overflow, 10 sub overflow
InHandler  output  1  high between handler entry and return
ErrCount  output  CNT_WIDTH  saturating count of taken exceptions

Behaviour:
- Reset (reset=0, async) values:
  - PC=RESET_PC; EPC=0; ErrTarget=0; Cause=0; InHandler=0; ErrCount=0; internal PendCause=0.
  - Err evaluates combinationally from its inputs, so it is 0 while InHandler=0 and no overflow condition is present.
- Overflow detection (combinational):
  - add = OpCode 00 with Funct 20, or OpCode 08 (addi); ovf when A[31]==B[31] and R[31]!=A[31].
  - sub = OpCode 00 with Funct 22; ovf when A[31]!=B[31] and R[31]!=A[31].
  - addu/addiu/subu and all other instructions never overflow.
  - Err = ovf & ~InHandler. No state qualification is needed; the controller samples Err only in execute states.
- PendCause: registered every clock in which Err=1 (01 add, 10 sub). It holds the cause across the controller's error cycle, when the ALU inputs are no longer valid.
- PC update on a clock edge, when PCWrite=1 or (PCWriteCond=1 and Zero=1):
  - PCErrSource=01: PC<=HANDLER_ADDR.
  - PCErrSource=10: PC<=EPC.
  - PCErrSource=00, PCSource=00: PC<=ALUResult.
  - PCSource=01: PC<=ALUOutReg.
  - PCSource=10: PC<={PC[31:28],Instruction[25:0],2'b00}.
  - PCSource=11: PC<=RsData.
  - PCErrSource=11: PC holds.
  - Otherwise PC holds.
- EPCWrite=1 on a clock edge:
  - EPC<=PC (pre-update value, i.e. the address after the faulting instruction).
  - Cause<=PendCause.
  - InHandler<=1.
  - ErrCount increments, saturating at all-ones.
  - Simultaneous PCWrite with PCErrSource=01 still loads HANDLER_ADDR; EPC captures the old PC.
- ErrTargetWrite=1 on a clock edge: ErrTarget<=Instruction[15:11] if OpCode==00, else Instruction[20:16].
- Handler return: an edge with PCWrite=1 and PCErrSource=10 clears InHandler. If EPCWrite is also 1 on that edge, EPCWrite wins and InHandler stays 1.
- Nested faults: while InHandler=1, Err is masked to 0, and EPC, Cause and ErrCount are not disturbed by handler arithmetic.
- Mid-operation reset: any edge-state is discarded immediately and all registers return to their reset values.

Test Plan:
- Reset release, then an IF edge with PCWrite=1, PCSource=00, ALUResult=32'h4 -> PC=32'h4, Err=0, ErrCount=0.
- add, A=32'h7FFF_FFFF, B=32'h1, R=32'h8000_0000 -> Err=1. Next edge with PCWrite, PCErrSource=01, EPCWrite, ErrTargetWrite, PC=32'h10, rd=5 -> PC=32'h180, EPC=32'h10, Cause=01, ErrTarget=5, InHandler=1, ErrCount=1.
- Inside the handler, sub with A=32'h8000_0000, B=32'h1 -> Err stays 0. Then PCWrite with PCErrSource=10 -> PC=32'h10, InHandler=0.
- beq with PCWriteCond=1, ALUOutReg=32'h40: Zero=0 -> PC holds; Zero=1 -> PC=32'h40. Then j with PC=32'h3000_0000, index=26'h10 -> PC=32'h3000_0040.
- addu with the same overflowing operands -> Err=0. addi overflow, rt=9 -> ErrTarget=9, Cause=01. After 300 exceptions with CNT_WIDTH=8 -> ErrCount=255.
- Assert reset=0 between an Err cycle and the EPCWrite edge -> all outputs at reset values immediately, and no later EPC capture occurs.
